// File: rtl/clock_set_ctrl.sv
// Settable HH:MM:SS clock. It has a prescaled one-second tick and a
// RUN / SET_HOUR / SET_MIN mode FSM that is driven by edge-detected buttons.
module clock_set_ctrl #(
  parameter int TICK_DIV = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] sec,
  output logic [7:0] minute,
  output logic [7:0] hour,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [7:0]    sec_next, min_next, hour_next;
  logic          btn_mode_q, btn_inc_q;
  logic          mode_press, inc_press;

  assign mode_press = btn_mode & ~btn_mode_q;
  assign inc_press  = btn_inc & ~btn_inc_q;
  assign tick       = (state == RUN) && (presc == LAST);
  assign mode       = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= RUN;
      presc      <= '0;
      sec        <= 8'd0;
      minute     <= 8'd0;
      hour       <= 8'd0;
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      sec        <= sec_next;
      minute     <= min_next;
      hour       <= hour_next;
      btn_mode_q <= btn_mode;
      btn_inc_q  <= btn_inc;
    end
  end

  // A mode press takes priority over an inc press. The prescaler is frozen at 0 outside RUN.
  always_comb begin
    state_next = state;
    presc_next = '0;
    sec_next   = sec;
    min_next   = minute;
    hour_next  = hour;
    case (state)
      RUN: begin
        presc_next = tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (sec == 8'd59) begin
            sec_next = 8'd0;
            if (minute == 8'd59) begin
              min_next  = 8'd0;
              hour_next = (hour == 8'd23) ? 8'd0 : hour + 8'd1;
            end else begin
              min_next = minute + 8'd1;
            end
          end else begin
            sec_next = sec + 8'd1;
          end
        end
        if (mode_press) state_next = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_press) state_next = SET_MIN;
        else if (inc_press) hour_next = (hour == 8'd23) ? 8'd0 : hour + 8'd1;
      end
      SET_MIN: begin
        if (mode_press) begin
          state_next = RUN;
          sec_next   = 8'd0;
        end else if (inc_press) begin
          min_next = (minute == 8'd59) ? 8'd0 : minute + 8'd1;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl with TICK_DIV=2.
// Each task checks its own expected values, which were worked out by hand.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] sec, minute, hour;
  logic [1:0] mode;
  logic       tick;

  int checks = 0;
  int passes = 0;

  clock_set_ctrl #(.TICK_DIV(2)) dut (
    .clk(clk), .resetn(resetn), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .minute(minute), .hour(hour), .mode(mode), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    cyc();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    cyc();
    btn_inc = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({sec, minute, hour} !== 24'd0) $display("[TB] FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", hour, minute, sec);
    else passes++;
    checks++;
    if (mode !== 2'd0) $display("[TB] FAIL reset_mode: got %0d expected 0", mode);
    else passes++;
    checks++;
    if (tick !== 1'b0) $display("[TB] FAIL reset_tick: got %0b expected 0", tick);
    else passes++;
    resetn = 1'b1;
  endtask

  // After reset, tick is high following every odd edge and sec equals edges/2 modulo 60.
  task automatic test_run_count();
    for (int i = 1; i <= 120; i++) begin
      cyc();
      checks++;
      if (tick !== 1'((i % 2) == 1)) $display("[TB] FAIL run_tick[%0d]: got %0b expected %0b", i, tick, (i % 2) == 1);
      else passes++;
      checks++;
      if (sec !== 8'((i / 2) % 60)) $display("[TB] FAIL run_sec[%0d]: got %0d expected %0d", i, sec, (i / 2) % 60);
      else passes++;
    end
    checks++;
    if (minute !== 8'd1 || hour !== 8'd0) $display("[TB] FAIL run_min_hour: got %0d:%0d expected 0:1", hour, minute);
    else passes++;
  endtask

  task automatic test_rollover();
    press_mode();
    checks++;
    if (mode !== 2'd1 || tick !== 1'b0) $display("[TB] FAIL enter_set_hour: got mode=%0d tick=%0b expected mode=1 tick=0", mode, tick);
    else passes++;
    for (int i = 0; i < 23; i++) press_inc();
    checks++;
    if (hour !== 8'd23 || minute !== 8'd1 || sec !== 8'd0) $display("[TB] FAIL set_hour_23: got %0d:%0d:%0d expected 23:1:0", hour, minute, sec);
    else passes++;
    press_mode();
    for (int i = 0; i < 58; i++) press_inc();
    checks++;
    if (mode !== 2'd2 || minute !== 8'd59 || hour !== 8'd23) $display("[TB] FAIL set_min_59: got mode=%0d %0d:%0d expected mode=2 23:59", mode, hour, minute);
    else passes++;
    press_mode();
    checks++;
    if (mode !== 2'd0 || sec !== 8'd0 || tick !== 1'b1) $display("[TB] FAIL back_to_run: got mode=%0d sec=%0d tick=%0b expected 0 0 1", mode, sec, tick);
    else passes++;
    for (int i = 0; i < 59; i++) begin
      cyc();
      cyc();
    end
    checks++;
    if ({hour, minute, sec} !== {8'd23, 8'd59, 8'd59}) $display("[TB] FAIL reach_235959: got %0d:%0d:%0d expected 23:59:59", hour, minute, sec);
    else passes++;
    checks++;
    if (tick !== 1'b1) $display("[TB] FAIL pre_wrap_tick: got %0b expected 1", tick);
    else passes++;
    cyc();
    checks++;
    if ({hour, minute, sec} !== 24'd0) $display("[TB] FAIL wrap_000000: got %0d:%0d:%0d expected 0:0:0", hour, minute, sec);
    else passes++;
  endtask

  task automatic test_held_inc();
    press_mode();
    btn_inc = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    btn_inc = 1'b0;
    cyc();
    checks++;
    if (hour !== 8'd1 || minute !== 8'd0 || sec !== 8'd0) $display("[TB] FAIL held_inc: got %0d:%0d:%0d expected 1:0:0", hour, minute, sec);
    else passes++;
    checks++;
    if (tick !== 1'b0 || mode !== 2'd1) $display("[TB] FAIL set_no_tick: got tick=%0b mode=%0d expected 0 1", tick, mode);
    else passes++;
  endtask

  task automatic test_simultaneous();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cyc();
    checks++;
    if (mode !== 2'd2 || hour !== 8'd1) $display("[TB] FAIL same_cycle: got mode=%0d hour=%0d expected 2 1", mode, hour);
    else passes++;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc();
  endtask

  task automatic test_min_wrap_and_reset();
    for (int i = 0; i < 59; i++) press_inc();
    checks++;
    if (minute !== 8'd59) $display("[TB] FAIL min_59: got %0d expected 59", minute);
    else passes++;
    press_inc();
    checks++;
    if (minute !== 8'd0 || hour !== 8'd1 || sec !== 8'd0) $display("[TB] FAIL min_wrap: got %0d:%0d:%0d expected 1:0:0", hour, minute, sec);
    else passes++;
    resetn  = 1'b0;
    btn_inc = 1'b1;
    cyc();
    checks++;
    if ({hour, minute, sec} !== 24'd0 || mode !== 2'd0 || tick !== 1'b0) $display("[TB] FAIL mid_set_reset: got %0d:%0d:%0d mode=%0d tick=%0b expected 0:0:0 0 0", hour, minute, sec, mode, tick);
    else passes++;
    resetn  = 1'b1;
    btn_inc = 1'b0;
  endtask

  task automatic test_run_ignores_inc();
    for (int i = 0; i < 5; i++) press_inc();
    checks++;
    if ({hour, minute, sec} !== {8'd0, 8'd0, 8'd5} || mode !== 2'd0) $display("[TB] FAIL run_ignores_inc: got %0d:%0d:%0d mode=%0d expected 0:0:5 0", hour, minute, sec, mode);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_rollover();
    test_held_inc();
    test_simultaneous();
    test_min_wrap_and_reset();
    test_run_ignores_inc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk is the clock, resetn is the reset, and all state SHALL be sampled on the rising edge of clk.
REQ-002 Parameter TICK_DIV, default 2: the number of clk cycles per one-second tick (minimum 2).
REQ-003 clk  input  1  system clock.
REQ-004 resetn  input  1  synchronous active-low reset.
REQ-005 btn_mode  input  1  mode button, level; already synchronous to clk.
REQ-006 btn_inc  input  1  increment button, level; already synchronous to clk.
REQ-007 sec  output  8  seconds, binary, range 0..59.
REQ-008 minute  output  8  minutes, binary, range 0..59.
REQ-009 hour  output  8  hours, binary, range 0..23.
REQ-010 mode  output  2  current state: 0=RUN, 1=SET_HOUR, 2=SET_MIN; 3 is never driven.
REQ-011 tick  output  1  one-cycle pulse marking each one-second tick in RUN.

Function
REQ-012 Each button SHALL be rising-edge detected: press = btn AND NOT btn_q, where btn_q is the button registered one cycle earlier.
REQ-013 A held button SHALL produce exactly one press.
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, and tick SHALL be 1 (combinational from the counter) in the cycle the count equals TICK_DIV-1.
REQ-015 In SET_HOUR and SET_MIN the prescaler SHALL be held at 0 and tick SHALL be 0.
REQ-016 On tick, sec SHALL increment at the same clock edge:
  - sec 59 -> 0 with minute+1;
  - minute 59 -> 0 with hour+1;
  - hour 23 -> 0.
  All carries SHALL take effect in that single edge, so 23:59:59 -> 00:00:00 in one cycle.
REQ-017 FSM transitions on a mode press SHALL be RUN -> SET_HOUR -> SET_MIN -> RUN; with no mode press the state is held.
REQ-018 In SET_HOUR, an inc press SHALL increment hour modulo 24 (23 -> 0), with no effect on minute or sec.
REQ-019 In SET_MIN, an inc press SHALL increment minute modulo 60 (59 -> 0), with no carry into hour and no effect on sec.
REQ-020 In RUN, inc presses SHALL be ignored.
REQ-021 On the SET_MIN -> RUN transition, sec SHALL be cleared to 0 and the prescaler SHALL restart at 0, so the first tick follows TICK_DIV cycles later.
REQ-022 If mode and inc presses occur in the same cycle, the mode transition SHALL take effect and the inc press SHALL be discarded.
REQ-023 All outputs except tick SHALL be registered, with one-cycle latency from the sampling edge to the visible update.
REQ-024 Time registers SHALL never hold out-of-range values, and arithmetic SHALL be 8-bit unsigned with no saturation.

Reset
REQ-025 While resetn=0 at a clk rising edge, the block SHALL set sec=0, minute=0, hour=0, mode=RUN, prescaler=0 and btn_q=0; tick SHALL then read 0.
REQ-026 Reset SHALL dominate any simultaneous tick or press, including reset asserted mid-SET.
REQ-027 After resetn rises, the first tick SHALL occur TICK_DIV cycles later.

Verification
REQ-028 Reset, TICK_DIV=2, run 120 cycles -> tick on every 2nd cycle; sec counts 0..59 and wraps to 0; minute=1, hour=0.
REQ-029 Set hour to 23 (23 inc presses in SET_HOUR), set minute to 59, press mode to return to RUN, run 60 ticks -> 23:59:00 reaches 23:59:59, next tick gives 00:00:00.
REQ-030 In SET_HOUR, btn_inc held high for 10 cycles -> hour increments by exactly 1.
REQ-031 In SET_HOUR, btn_mode and btn_inc rise in the same cycle -> mode=2 next cycle, hour unchanged.
REQ-032 In SET_MIN with minute=59, inc press -> minute=0, hour unchanged; then resetn low for one edge -> all outputs 0 and mode=0 next cycle.
REQ-033 In RUN, 5 inc presses -> sec/minute/hour follow ticks only, unaffected by presses.
